// File: rtl/gps_fe_pkg.sv
// Shared constants, capture FSM state type and test-pattern LFSR step for the
// GPS front-end sample capture block.
package gps_fe_pkg;

  localparam int SYNC_STAGES = 2;

  localparam int             LFSR_W    = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;
  // x^7 + x^6 + 1: feedback taken from bits 6 and 5
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } capture_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fe_sync_edge.sv
// Two-flop synchroniser for the front-end clock and data pins, with a third
// clock flop used to produce a one-cycle rising-edge strobe.
module fe_sync_edge
  import gps_fe_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fe_clk,
  input  logic [W-1:0] fe_data,
  output logic [W-1:0] data_sync,
  output logic         edge_pulse
);

  // clk_sr[0] = sync1, [1] = sync2, [2] = sync3
  logic [SYNC_STAGES:0]            clk_sr;
  logic [SYNC_STAGES-1:0][W-1:0]   data_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sr  <= '0;
      data_sr <= '0;
    end else begin
      clk_sr  <= {clk_sr[SYNC_STAGES-1:0], fe_clk};
      data_sr <= {data_sr[SYNC_STAGES-2:0], fe_data};
    end
  end

  assign edge_pulse = clk_sr[SYNC_STAGES-1] & ~clk_sr[SYNC_STAGES];
  assign data_sync  = data_sr[SYNC_STAGES-1];

endmodule

// File: rtl/frontend_sample_capture.sv
// Packs synchronised front-end samples into words behind a one-entry holding
// register. Define FE_TEST_PATTERN_EN to add test_mode and the LFSR source.
module frontend_sample_capture
  import gps_fe_pkg::*;
#(
  parameter int SAMPLE_BITS = 2,
  parameter int PACK        = 8,
  parameter int DROP_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        fe_clk_in,
  input  logic [SAMPLE_BITS-1:0]      fe_data_in,
`ifdef FE_TEST_PATTERN_EN
  input  logic                        test_mode,
`endif
  output logic [SAMPLE_BITS*PACK-1:0] word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  input  logic                        clear_overflow,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_count
);

  localparam int WORD_W = SAMPLE_BITS * PACK;
  localparam int IDX_W  = $clog2(PACK);

  // Handshake: a word transfers on any clk edge where word_valid & word_ready;
  // word_valid never drops without a transfer, word_out is stable while valid.

  logic [SAMPLE_BITS-1:0] data_sync;
  logic                   fe_edge;
  logic [SAMPLE_BITS-1:0] sample;

  capture_state_t   state_q, state_d;
  logic             capture;
  logic [IDX_W-1:0] idx_q;
  logic [WORD_W-1:0] pack_q;
  logic             done_q;
  logic             last_sample;
  logic             drop;

  fe_sync_edge #(.W(SAMPLE_BITS)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .fe_clk     (fe_clk_in),
    .fe_data    (fe_data_in),
    .data_sync  (data_sync),
    .edge_pulse (fe_edge)
  );

`ifdef FE_TEST_PATTERN_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_next;

  assign lfsr_next = lfsr_step(lfsr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    lfsr_q <= LFSR_SEED;
    else if (fe_edge && test_mode) lfsr_q <= lfsr_next;
  end

  assign sample = test_mode ? lfsr_next[SAMPLE_BITS-1:0] : data_sync;
`else
  assign sample = data_sync;
`endif

  assign last_sample = (idx_q == IDX_W'(PACK - 1));

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = FILL;
      FILL: begin
        if (!enable) state_d = IDLE;
        else         capture = fe_edge;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Leaving or sitting in IDLE forgets the partial word by rewinding idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      pack_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= capture && last_sample;
      if (state_d == IDLE) begin
        idx_q <= '0;
      end else if (capture) begin
        pack_q[int'(idx_q)*SAMPLE_BITS +: SAMPLE_BITS] <= sample;
        idx_q <= last_sample ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign drop = done_q && word_valid && !word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (done_q && !drop) begin
        word_out   <= pack_q;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      // a drop in the same cycle as clear_overflow keeps the flag set
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      if (drop && drop_count != {DROP_W{1'b1}})
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_frontend_sample_capture.sv
// Directed bench for frontend_sample_capture: words expected from the stimulus
// are queued and checked as the DUT hands them over.
module tb_frontend_sample_capture;

  localparam int SB = 2;
  localparam int PK = 8;
  localparam int DW = 16;
  localparam int WW = SB * PK;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fe_clk_in;
  logic [SB-1:0] fe_data_in;
`ifdef FE_TEST_PATTERN_EN
  logic          test_mode;
`endif
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic          clear_overflow;
  logic          overflow;
  logic [DW-1:0] drop_count;

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [2:0]    exp_idx;
  logic [6:0]    tb_lfsr;

  always #5 clk = ~clk;

  frontend_sample_capture #(
    .SAMPLE_BITS (SB),
    .PACK        (PK),
    .DROP_W      (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fe_clk_in      (fe_clk_in),
    .fe_data_in     (fe_data_in),
`ifdef FE_TEST_PATTERN_EN
    .test_mode      (test_mode),
`endif
    .word_out       (word_out),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest queued word.
  always @(negedge clk) begin
    if (!reset && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_word: observed %0h expected none", word_out);
      end else begin
        chk("word_out", word_out, exp_q.pop_front());
      end
    end
  end

  // One front-end clock period: 4 clk low with new data, then high.
  task automatic pulse(input logic [SB-1:0] s, input bit lat, input bit clr);
    logic [2:0] nxt;
    bit         wrap;
    nxt  = exp_idx + 3'd1;
    wrap = (exp_idx == 3'd7);
    @(posedge clk); #1;
    fe_data_in = s;
    fe_clk_in  = 1'b0;
    repeat (4) @(posedge clk);
    #1 fe_clk_in = 1'b1;
    repeat (3) @(negedge clk);
    if (lat) chk("idx_before_3rd_edge", dut.idx_q, exp_idx);
    @(posedge clk); #1;
    if (clr) clear_overflow = 1'b1;
    @(negedge clk);
    if (lat) begin
      chk("idx_at_3rd_edge", dut.idx_q, nxt);
      chk("pack_slot", dut.pack_q[int'(exp_idx)*SB +: SB], s);
      if (wrap) chk("valid_not_yet", word_valid, 1'b0);
    end
    @(posedge clk); #1 clear_overflow = 1'b0;
    @(negedge clk);
    if (lat && wrap) chk("valid_next_edge", word_valid, 1'b1);
    exp_idx = nxt;
  endtask

  task automatic capture_word(input logic [WW-1:0] dw, input logic [WW-1:0] ew,
                              input bit push, input bit lat, input bit clr);
    if (push) exp_q.push_back(ew);
    for (int k = 0; k < PK; k++)
      pulse(dw[k*SB +: SB], lat, clr && (k == PK - 1));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WW-1:0] w;
    logic [WW-1:0] ew;
    reset = 1'b1; enable = 1'b0; fe_clk_in = 1'b0; fe_data_in = '0;
    word_ready = 1'b1; clear_overflow = 1'b0; exp_idx = 3'd0;
`ifdef FE_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    cycles(3);
    chk("rst_word_out", word_out, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_idx", dut.idx_q, 0);
    reset = 1'b0;
    enable = 1'b1;
    cycles(2);

    // Basic word with latency checks on every sample.
    capture_word(16'hE4E4, 16'hE4E4, 1'b1, 1'b1, 1'b0);
    cycles(2);
    chk("word1_consumed", word_valid, 0);
    chk("word1_queue", exp_q.size(), 0);

    // Back-pressure: second word dropped.
    word_ready = 1'b0;
    w = 16'($urandom_range(0, 65535));
    capture_word(w, w, 1'b1, 1'b0, 1'b0);
    ew = w;
    w = 16'($urandom_range(0, 65535));
    capture_word(w, w, 1'b0, 1'b0, 1'b0);
    cycles(1);
    chk("held_valid", word_valid, 1);
    chk("held_word", word_out, ew);
    chk("drop_count_1", drop_count, 1);
    chk("overflow_1", overflow, 1);
    word_ready = 1'b1;
    cycles(2);
    chk("held_consumed", word_valid, 0);
    chk("held_queue", exp_q.size(), 0);

    // Clear alone, then a drop coinciding with clear.
    word_ready = 1'b0;
    w = 16'($urandom_range(0, 65535));
    capture_word(w, w, 1'b1, 1'b0, 1'b0);
    clear_overflow = 1'b1;
    cycles(1);
    clear_overflow = 1'b0;
    cycles(1);
    chk("overflow_cleared", overflow, 0);
    chk("drop_kept_on_clear", drop_count, 1);
    w = 16'($urandom_range(0, 65535));
    capture_word(w, w, 1'b0, 1'b0, 1'b1);
    chk("overflow_set_wins", overflow, 1);
    chk("drop_count_2", drop_count, 2);
    clear_overflow = 1'b1;
    cycles(1);
    clear_overflow = 1'b0;
    cycles(1);
    chk("overflow_clear_2", overflow, 0);
    chk("drop_count_still_2", drop_count, 2);
    word_ready = 1'b1;
    cycles(2);
    chk("drain_queue", exp_q.size(), 0);

    // Partial word discarded on enable low.
    for (int k = 0; k < 5; k++) pulse(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    chk("partial_idx", dut.idx_q, 5);
    enable = 1'b0;
    cycles(2);
    chk("disable_idx", dut.idx_q, 0);
    enable = 1'b1;
    exp_idx = 3'd0;
    cycles(2);
    w = 16'($urandom_range(0, 65535));
    capture_word(w, w, 1'b1, 1'b1, 1'b0);
    cycles(2);
    chk("reenable_queue", exp_q.size(), 0);

    // Reset with a held word and idx = 4.
    word_ready = 1'b0;
    w = 16'($urandom_range(1, 65535));
    capture_word(w, w, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) pulse(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    chk("pre_reset_valid", word_valid, 1);
    chk("pre_reset_idx", dut.idx_q, 4);
    #2;
    reset = 1'b1;
    fe_clk_in = 1'b0;
    #1;
    chk("async_word_valid", word_valid, 0);
    chk("async_word_out", word_out, 0);
    chk("async_drop_count", drop_count, 0);
    chk("async_overflow", overflow, 0);
    chk("async_idx", dut.idx_q, 0);
    cycles(2);
    reset = 1'b0;
    word_ready = 1'b1;
    exp_idx = 3'd0;
    cycles(2);
    w = 16'($urandom_range(0, 65535));
    capture_word(w, w, 1'b1, 1'b1, 1'b0);
    cycles(2);
    chk("post_reset_queue", exp_q.size(), 0);

`ifdef FE_TEST_PATTERN_EN
    // Test pattern: samples come from the LFSR, seeded at the last reset.
    test_mode = 1'b1;
    tb_lfsr = 7'h7F;
    ew = '0;
    for (int k = 0; k < PK; k++) begin
      tb_lfsr = {tb_lfsr[5:0], tb_lfsr[6] ^ tb_lfsr[5]};
      ew[k*SB +: SB] = tb_lfsr[SB-1:0];
    end
    w = 16'($urandom_range(0, 65535));
    capture_word(w, ew, 1'b1, 1'b0, 1'b0);
    cycles(2);
    chk("lfsr_queue", exp_q.size(), 0);
    test_mode = 1'b0;
`endif

    cycles(4);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
